// File: rtl/btb_upd_pkg.sv
// Shared types for the BTB update queue: operation encoding, entry layout and
// the resolved-branch classifier.
package btb_upd_pkg;

  localparam int BTB_PC_BITS = 32;

  typedef enum logic {
    BTB_OP_WRITE = 1'b0,
    BTB_OP_INVAL = 1'b1
  } btb_op_e;

  typedef struct packed {
    btb_op_e                op;
    logic [BTB_PC_BITS-1:0] pc;
    logic [BTB_PC_BITS-1:0] target;
  } btb_upd_entry_t;

  typedef struct packed {
    logic    valid;
    btb_op_e op;
  } btb_cls_t;

  // target_miss is the caller's predicted-vs-actual target comparison
  function automatic btb_cls_t btb_classify(input logic taken, input logic pred_hit,
                                            input logic target_miss);
    btb_cls_t c;
    c.valid = 1'b0;
    c.op    = BTB_OP_WRITE;
    if (taken && (!pred_hit || target_miss)) begin
      c.valid = 1'b1;
    end else if (!taken && pred_hit) begin
      c.valid = 1'b1;
      c.op    = BTB_OP_INVAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// DEPTH-entry FIFO of BTB operations with occupancy count, synchronous flush
// and an optional in-place update port that targets the youngest non-head match.
module btb_upd_fifo
  import btb_upd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_BITS = 32,
  parameter bit MERGE   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   merge,
  input  btb_op_e                push_op,
  input  logic [PC_BITS-1:0]     push_pc,
  input  logic [PC_BITS-1:0]     push_target,
  input  logic                   pop,
  output btb_op_e                head_op,
  output logic [PC_BITS-1:0]     head_pc,
  output logic [PC_BITS-1:0]     head_target,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   merge_hit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  btb_op_e             op_q  [DEPTH];
  logic [PC_BITS-1:0]  pc_q  [DEPTH];
  logic [PC_BITS-1:0]  tgt_q [DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       merge_idx;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign head_op     = op_q[rd_ptr];
  assign head_pc     = pc_q[rd_ptr];
  assign head_target = tgt_q[rd_ptr];

  // Head is skipped because it may be on the BTB port this very cycle;
  // ascending scan leaves the youngest match selected.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = rd_ptr;
    if (MERGE) begin
      for (int k = 1; k < DEPTH; k++) begin
        if (k < int'(count) && pc_q[rd_ptr + AW'(k)] == push_pc) begin
          merge_hit = 1'b1;
          merge_idx = rd_ptr + AW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= BTB_OP_WRITE;
        pc_q[i]  <= '0;
        tgt_q[i] <= '0;
      end
    end else if (merge) begin
      op_q[merge_idx]  <= push_op;
      tgt_q[merge_idx] <= push_target;
    end else if (push) begin
      op_q[wr_ptr]  <= push_op;
      pc_q[wr_ptr]  <= push_pc;
      tgt_q[wr_ptr] <= push_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/btb_update_queue.sv
// Classifies resolved branches into BTB writes/invalidations and drains them one
// per cycle. Define BTB_UPD_MERGE_EN to fold repeat reports for a queued PC in place.
module btb_update_queue
  import btb_upd_pkg::*;
#(
  parameter int PC_BITS = 32,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [PC_BITS-1:0]     res_pc,
  input  logic [PC_BITS-1:0]     res_target,
  input  logic                   res_taken,
  input  logic                   res_pred_hit,
  input  logic [PC_BITS-1:0]     res_pred_target,
  input  logic                   flush,
  input  logic                   btb_stall,
  output logic                   wr_en,
  output logic [PC_BITS-1:0]     orig_pc,
  output logic [PC_BITS-1:0]     target_pc,
  output logic                   invalidate,
  output logic [PC_BITS-1:0]     pc_invalid,
  output logic [$clog2(DEPTH):0] pending
);

`ifdef BTB_UPD_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  btb_cls_t            cls;
  btb_op_e             head_op;
  logic [PC_BITS-1:0]  head_pc;
  logic [PC_BITS-1:0]  head_target;
  logic                full;
  logic                empty;
  logic                cam_hit;
  logic                merge_hit;
  logic                accept;
  logic                push;
  logic                merge;
  logic                pop;

  assign cls       = btb_classify(res_taken, res_pred_hit, res_pred_target != res_target);
  assign merge_hit = cam_hit & cls.valid;
  assign res_ready = !full | merge_hit;
  assign accept    = res_valid & res_ready;
  assign merge     = accept & merge_hit;
  assign push      = accept & cls.valid & !merge_hit;
  assign pop       = !empty & !btb_stall;

  btb_upd_fifo #(
    .DEPTH   (DEPTH),
    .PC_BITS (PC_BITS),
    .MERGE   (MERGE_EN)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push        (push),
    .merge       (merge),
    .push_op     (cls.op),
    .push_pc     (res_pc),
    .push_target (res_target),
    .pop         (pop),
    .head_op     (head_op),
    .head_pc     (head_pc),
    .head_target (head_target),
    .count       (pending),
    .full        (full),
    .empty       (empty),
    .merge_hit   (cam_hit)
  );

  // Strobes come straight off the registered head; data ports are don't-care while stalled
  assign wr_en      = pop & (head_op == BTB_OP_WRITE);
  assign invalidate = pop & (head_op == BTB_OP_INVAL);
  assign orig_pc    = head_pc;
  assign target_pc  = head_target;
  assign pc_invalid = head_pc;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: per-cycle vector table plus wrap,
// async-reset and (with BTB_UPD_MERGE_EN) merge sequences.
module tb_btb_update_queue;

  localparam int DEPTH = 4;
  localparam int PCB   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            res_valid;
  logic            res_ready;
  logic [PCB-1:0]  res_pc;
  logic [PCB-1:0]  res_target;
  logic            res_taken;
  logic            res_pred_hit;
  logic [PCB-1:0]  res_pred_target;
  logic            flush;
  logic            btb_stall;
  logic            wr_en;
  logic [PCB-1:0]  orig_pc;
  logic [PCB-1:0]  target_pc;
  logic            invalidate;
  logic [PCB-1:0]  pc_invalid;
  logic [2:0]      pending;

  int checks   = 0;
  int failures = 0;

  btb_update_queue #(.PC_BITS(PCB), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_pc          (res_pc),
    .res_target      (res_target),
    .res_taken       (res_taken),
    .res_pred_hit    (res_pred_hit),
    .res_pred_target (res_pred_target),
    .flush           (flush),
    .btb_stall       (btb_stall),
    .wr_en           (wr_en),
    .orig_pc         (orig_pc),
    .target_pc       (target_pc),
    .invalidate      (invalidate),
    .pc_invalid      (pc_invalid),
    .pending         (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        ph;
    logic [31:0] pt;
    logic        st;
    logic        fl;
    logic        e_wr;
    logic        e_inv;
    logic [31:0] e_pc;
    logic [31:0] e_tgt;
    logic [2:0]  e_pend;
    logic        e_rdy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [31:0] tgt, logic tk, logic ph,
                              logic [31:0] pt, logic st, logic fl, logic e_wr, logic e_inv,
                              logic [31:0] e_pc, logic [31:0] e_tgt, logic [2:0] e_pend,
                              logic e_rdy);
    vec_t r;
    r.v = v; r.pc = pc; r.tgt = tgt; r.tk = tk; r.ph = ph; r.pt = pt; r.st = st; r.fl = fl;
    r.e_wr = e_wr; r.e_inv = e_inv; r.e_pc = e_pc; r.e_tgt = e_tgt;
    r.e_pend = e_pend; r.e_rdy = e_rdy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    res_valid       = x.v;
    res_pc          = x.pc;
    res_target      = x.tgt;
    res_taken       = x.tk;
    res_pred_hit    = x.ph;
    res_pred_target = x.pt;
    btb_stall       = x.st;
    flush           = x.fl;
  endtask

  task automatic check_outputs(input string tag, input vec_t x);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(x.e_wr));
    chk({tag, ".invalidate"}, 32'(invalidate), 32'(x.e_inv));
    chk({tag, ".pending"}, 32'(pending), 32'(x.e_pend));
    chk({tag, ".res_ready"}, 32'(res_ready), 32'(x.e_rdy));
    if (x.e_wr) begin
      chk({tag, ".orig_pc"}, orig_pc, x.e_pc);
      chk({tag, ".target_pc"}, target_pc, x.e_tgt);
    end
    if (x.e_inv) chk({tag, ".pc_invalid"}, pc_invalid, x.e_pc);
  endtask

  vec_t idle;

  initial begin
    logic [31:0] sb[$];
    logic [31:0] exp_pc;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    drive(idle);

    // v  pc      tgt     tk ph pt     st fl | wr inv e_pc   e_tgt   pend rdy
    vq.push_back(mk(1, 32'h100, 32'h200, 1, 0, 32'h0,   0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 1, 0, 32'h100, 32'h200, 1, 1));
    vq.push_back(mk(1, 32'h104, 32'h0,   0, 1, 32'h0,   0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(1, 32'h108, 32'h300, 1, 1, 32'h300, 0, 0, 0, 1, 32'h104, 0,       1, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(1, 32'h10,  32'h1010, 1, 0, 0,      1, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(1, 32'h20,  32'h1020, 1, 0, 0,      1, 0, 0, 0, 0,       0,       1, 1));
    vq.push_back(mk(1, 32'h30,  32'h1030, 1, 0, 0,      1, 0, 0, 0, 0,       0,       2, 1));
    vq.push_back(mk(1, 32'h40,  32'h1040, 1, 0, 0,      1, 0, 0, 0, 0,       0,       3, 1));
    vq.push_back(mk(1, 32'h50,  32'h1050, 1, 0, 0,      1, 0, 0, 0, 0,       0,       4, 0));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       1, 0, 0, 0, 0,       0,       4, 0));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 1, 0, 32'h10,  32'h1010, 4, 0));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 1, 0, 32'h20,  32'h1020, 3, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 1, 0, 32'h30,  32'h1030, 2, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 1, 0, 32'h40,  32'h1040, 1, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(1, 32'h11,  32'h1011, 1, 0, 0,      1, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(1, 32'h22,  32'h1022, 1, 0, 0,      1, 0, 0, 0, 0,       0,       1, 1));
    vq.push_back(mk(1, 32'h33,  32'h1033, 1, 0, 0,      1, 0, 0, 0, 0,       0,       2, 1));
    vq.push_back(mk(1, 32'h44,  32'h1044, 1, 0, 0,      1, 1, 0, 0, 0,       0,       3, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(1, 32'h55,  32'h1055, 1, 0, 0,      0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 1, 0, 32'h55,  32'h1055, 1, 1));
    vq.push_back(mk(1, 32'h60,  32'h80,  1, 1, 32'h70,  0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 1, 0, 32'h60,  32'h80,  1, 1));
    vq.push_back(mk(1, 32'h90,  32'h0,   0, 0, 0,       0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(1, 32'h77,  32'h1077, 1, 0, 0,      1, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 1, 1, 0, 32'h77,  32'h1077, 1, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 0, 0, 0,       0,       0, 1));
`ifdef BTB_UPD_MERGE_EN
    vq.push_back(mk(1, 32'h10,  32'h200, 1, 0, 0,      1, 0, 0, 0, 0,       0,       0, 1));
    vq.push_back(mk(1, 32'h20,  32'h300, 1, 0, 0,      1, 0, 0, 0, 0,       0,       1, 1));
    vq.push_back(mk(1, 32'h20,  32'h0,   0, 1, 0,      1, 0, 0, 0, 0,       0,       2, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       1, 0, 0, 0, 0,       0,       2, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 1, 0, 32'h10,  32'h200, 2, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 0, 1, 32'h20,  0,       1, 1));
    vq.push_back(mk(0, 0,       0,       0, 0, 0,       0, 0, 0, 0, 0,       0,       0, 1));
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.pending", 32'(pending), 32'd0);
    chk("reset.res_ready", 32'(res_ready), 32'd1);
    chk("reset.wr_en", 32'(wr_en), 32'd0);
    chk("reset.invalidate", 32'(invalidate), 32'd0);
    chk("reset.orig_pc", orig_pc, 32'd0);
    chk("reset.target_pc", target_pc, 32'd0);
    chk("reset.pc_invalid", pc_invalid, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i]);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vq[i]);
    end

    // Back-to-back push/pop across several pointer wraps
    for (int k = 0; k <= 3 * DEPTH + 1; k++) begin
      @(posedge clk); #1;
      drive(idle);
      if (k < 3 * DEPTH) begin
        res_valid  = 1'b1;
        res_pc     = 32'h1000 + 32'(k) * 32'h10;
        res_target = 32'h2000 + 32'(k);
        res_taken  = 1'b1;
        sb.push_back(res_pc);
      end
      @(negedge clk);
      if (k == 0 || k == 3 * DEPTH + 1) begin
        chk($sformatf("wrap%0d.wr_en", k), 32'(wr_en), 32'd0);
        chk($sformatf("wrap%0d.pending", k), 32'(pending), 32'd0);
      end else begin
        exp_pc = sb.pop_front();
        chk($sformatf("wrap%0d.wr_en", k), 32'(wr_en), 32'd1);
        chk($sformatf("wrap%0d.orig_pc", k), orig_pc, exp_pc);
        chk($sformatf("wrap%0d.target_pc", k), target_pc, 32'h2000 + 32'(k - 1));
        chk($sformatf("wrap%0d.pending", k), 32'(pending), 32'd1);
      end
    end

    // Asynchronous reset while an entry is on the BTB port
    @(posedge clk); #1;
    drive(idle);
    btb_stall = 1'b1;
    res_valid = 1'b1; res_taken = 1'b1; res_pc = 32'hA0; res_target = 32'hB0;
    @(posedge clk); #1;
    res_pc = 32'hA4; res_target = 32'hB4;
    @(posedge clk); #1;
    drive(idle);
    @(negedge clk);
    chk("arst.pending_before", 32'(pending), 32'd2);
    chk("arst.wr_en_before", 32'(wr_en), 32'd1);
    chk("arst.orig_pc_before", orig_pc, 32'hA0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.pending", 32'(pending), 32'd0);
    chk("arst.wr_en", 32'(wr_en), 32'd0);
    chk("arst.res_ready", 32'(res_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst.after_pending", 32'(pending), 32'd0);
    chk("arst.after_wr_en", 32'(wr_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
